jtag_axi_master_ctrl: RTL and testbench
=======================================

Name: jtag_axi_master_ctrl

Overview:
Sequences single AXI4-Lite transactions from the JTAG address/data registers. On a start pulse, decoded from UPDATE_DR of the control instruction, it latches address, write data, strobe and direction. It then drives the AXI4-Lite master channels to completion and exposes status plus read data for capture back into the JTAG shift register. It sits between the JTAG data-register block and the AXI interconnect (or a CDC bridge), in the tck domain.

Parameters:
ADDR_WIDTH, 32, AXI address width.
DATA_WIDTH, 32, AXI data width; strobe width is DATA_WIDTH/8.
TIMEOUT_CYCLES, 1024, maximum wait cycles per transaction; 0 disables the timeout.

Ports:
tck  input  1  block clock.
trst  input  1  reset; synchronous to tck, active-high.
start_i  input  1  one-cycle request pulse.
write_i  input  1  1 = write, 0 = read; sampled with start_i.
addr_i  input  ADDR_WIDTH  transaction address; sampled with start_i.
wdata_i  input  DATA_WIDTH  write data; sampled with start_i.
wstrb_i  input  DATA_WIDTH/8  write strobes; sampled with start_i.
busy_o  output  1  transaction in flight.
done_o  output  1  sticky: last transaction completed (or timed out).
resp_o  output  2  last BRESP/RRESP, or 2'b10 on timeout.
timeout_o  output  1  sticky: last transaction aborted by timeout.
overrun_o  output  1  sticky: start_i arrived while busy.
rdata_o  output  DATA_WIDTH  last read data.
txn_cnt_o  output  16  count of finished transactions; wraps.
AXI4-Lite master: awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arvalid/arready, rdata/rresp/rvalid/rready. All m_axi_* prefixed; standard widths; awprot/arprot tied to 3'b000.

Behaviour:
- Reset (trst=1 at a tck edge): state IDLE; all valids, ready outputs and status outputs 0; rdata_o 0; txn_cnt_o 0; latched address/data 0.
- A reset mid-transaction drops every valid/ready on that edge. No completion is recorded.
- FSM states: IDLE, WR (AW+W), WR_RESP, RD_ADDR, RD_DATA.
- IDLE + start_i=1 at edge N: latch the inputs; clear done_o, timeout_o, overrun_o and resp_o.
  - Write: go to WR; m_axi_awvalid and m_axi_wvalid are high from cycle N+1.
  - Read: go to RD_ADDR; m_axi_arvalid is high from cycle N+1.
  - busy_o=1 from N+1.
- start_i while not IDLE: ignored, overrun_o set to 1. The in-flight transaction is unaffected.
- WR: awvalid and wvalid are tracked independently. Each drops on the edge its ready is seen; address/data are held stable until then.
  - aw and w handshakes may occur in the same or different cycles.
  - When both are done, go to WR_RESP. bready=1 in WR_RESP only.
- WR_RESP + bvalid: latch bresp into resp_o. Go to IDLE, done_o=1, busy_o=0, txn_cnt_o+1.
- RD_ADDR + arready: go to RD_DATA. rready=1 in RD_DATA only.
- RD_DATA + rvalid: latch rdata into rdata_o and rresp into resp_o; finish as for writes.
- rdata_o changes only on a completed read. Writes and timeouts leave it unchanged.
- Latency: minimum 3 cycles from start_i to done_o with a zero-wait slave, for both read and write.
- Timeout:
  - 16-bit counter, cleared on leaving IDLE, incremented each non-IDLE cycle.
  - When it reaches TIMEOUT_CYCLES with no completion in that cycle: drop all valids/readies, resp_o=2'b10, timeout_o=1, done_o=1, txn_cnt_o+1, go to IDLE.
  - This is a deliberate debug abort; the interconnect must be reset by software afterwards.
  - If completion and timeout coincide in the same cycle, completion wins.
- Counter wraps from 16'hFFFF to 0.

Decomposition:
- jtag_pkg gains:
  - axi_ctrl_fsm_t enum (the five states).
  - axi_resp_t (OKAY/EXOKAY/SLVERR/DECERR).
  - A localparam for the timeout response code.
- No sub-module. The timeout counter is inline; the FSM and datapath fit in one file.

Test Plan:
1. Zero-wait write, addr 32'h1000_0010, wdata 32'hDEAD_BEEF, wstrb 4'hF -> aw/w valid at N+1; done_o=1 and resp_o=0 at N+3; txn_cnt_o=1.
2. Read with a 5-cycle arready delay, slave returns 32'hCAFE_F00D/OKAY -> arvalid held with stable araddr; rdata_o=32'hCAFE_F00D; busy_o low after rvalid.
3. Write with wready 3 cycles before awready -> wvalid drops after its handshake, awvalid stays high; exactly one of each handshake; bready only after both.
4. Slave never responds, TIMEOUT_CYCLES=16 -> abort 16 cycles after leaving IDLE; resp_o=2'b10, timeout_o=1, rdata_o unchanged.
5. start_i pulsed during RD_DATA -> overrun_o=1; the original read completes; cleared by the next accepted start.
6. trst asserted during WR_RESP -> all AXI outputs 0 next edge; done_o=0; txn_cnt_o=0; a new write then completes normally.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared types for the JTAG debug block: AXI master sequencer states and response codes.
package jtag_pkg;

    // Five-state sequencer: idle, write address+data, write response, read address, read data
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_DATA = 3'd4
    } axi_ctrl_fsm_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_t;

    // Reported when a transaction is aborted because the slave stopped answering
    localparam axi_resp_t TIMEOUT_RESP = RESP_SLVERR;

endpackage

// File: rtl/jtag_axi_master_ctrl.sv
// Runs one AXI4-Lite transaction per start pulse from the JTAG data registers and
// keeps sticky status plus read data for capture back into the shift register.
module jtag_axi_master_ctrl
    import jtag_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    tck,
    input  logic                    trst,
    input  logic                    start_i,
    input  logic                    write_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [1:0]              resp_o,
    output logic                    timeout_o,
    output logic                    overrun_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic [15:0]             txn_cnt_o,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]              m_axi_awprot,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]              m_axi_arprot,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    localparam logic [15:0] TMO_LIMIT = TIMEOUT_CYCLES[15:0];

    axi_ctrl_fsm_t state, state_nxt;

    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH/8-1:0] wstrb_q;
    logic                    aw_done, w_done;
    logic [15:0]             tcnt;
    logic [15:0]             tcnt_inc;
    logic                    accept, aw_hs, w_hs, complete, tmo_hit;

    // Channel outputs are pure decodes of the registered state, so a reset drops them at once
    assign busy_o        = (state != ST_IDLE);
    assign m_axi_awaddr  = addr_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_awvalid = (state == ST_WR) && !aw_done;
    assign m_axi_wvalid  = (state == ST_WR) && !w_done;
    assign m_axi_bready  = (state == ST_WR_RESP);
    assign m_axi_arvalid = (state == ST_RD_ADDR);
    assign m_axi_rready  = (state == ST_RD_DATA);

    // State register
    always_ff @(posedge tck) begin
        if (trst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Next-state decode; a timeout overrides any channel progress, but not a completion
    always_comb begin
        state_nxt = state;
        accept    = (state == ST_IDLE) && start_i;
        aw_hs     = m_axi_awvalid && m_axi_awready;
        w_hs      = m_axi_wvalid && m_axi_wready;
        complete  = ((state == ST_WR_RESP) && m_axi_bvalid) ||
                    ((state == ST_RD_DATA) && m_axi_rvalid);
        tcnt_inc  = tcnt + 16'd1;
        tmo_hit   = (TIMEOUT_CYCLES != 0) && (state != ST_IDLE) &&
                    (tcnt_inc == TMO_LIMIT) && !complete;
        case (state)
            ST_IDLE:    if (start_i) state_nxt = write_i ? ST_WR : ST_RD_ADDR;
            ST_WR:      if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = ST_WR_RESP;
            ST_WR_RESP: if (m_axi_bvalid) state_nxt = ST_IDLE;
            ST_RD_ADDR: if (m_axi_arready) state_nxt = ST_RD_DATA;
            ST_RD_DATA: if (m_axi_rvalid) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
        if (tmo_hit) state_nxt = ST_IDLE;
    end

    // Request latch, per-channel handshake tracking, timeout counter and sticky status
    always_ff @(posedge tck) begin
        if (trst) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            tcnt      <= '0;
            done_o    <= 1'b0;
            timeout_o <= 1'b0;
            overrun_o <= 1'b0;
            resp_o    <= 2'b00;
            rdata_o   <= '0;
            txn_cnt_o <= '0;
        end else if (accept) begin
            addr_q    <= addr_i;
            wdata_q   <= wdata_i;
            wstrb_q   <= wstrb_i;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            tcnt      <= '0;
            done_o    <= 1'b0;
            timeout_o <= 1'b0;
            overrun_o <= 1'b0;
            resp_o    <= 2'b00;
        end else if (state != ST_IDLE) begin
            tcnt <= tcnt_inc;
            if (start_i) overrun_o <= 1'b1;
            if (aw_hs)   aw_done   <= 1'b1;
            if (w_hs)    w_done    <= 1'b1;
            if (complete) begin
                done_o    <= 1'b1;
                txn_cnt_o <= txn_cnt_o + 16'd1;
                if (state == ST_RD_DATA) begin
                    resp_o  <= m_axi_rresp;
                    rdata_o <= m_axi_rdata;
                end else begin
                    resp_o  <= m_axi_bresp;
                end
            end else if (tmo_hit) begin
                done_o    <= 1'b1;
                timeout_o <= 1'b1;
                resp_o    <= TIMEOUT_RESP;
                txn_cnt_o <= txn_cnt_o + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_jtag_axi_master_ctrl.sv
// Directed bench for jtag_axi_master_ctrl; the slave side is driven cycle by cycle from each task.
module tb_jtag_axi_master_ctrl;

    logic        tck = 1'b0;
    logic        trst;
    logic        start_i, write_i;
    logic [31:0] addr_i, wdata_i;
    logic [3:0]  wstrb_i;
    logic        busy_o, done_o, timeout_o, overrun_o;
    logic [1:0]  resp_o;
    logic [31:0] rdata_o;
    logic [15:0] txn_cnt_o;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    int checks = 0;
    int errors = 0;
    int aw_hs_cnt = 0;
    int w_hs_cnt = 0;

    always #5 tck = ~tck;

    jtag_axi_master_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .tck(tck), .trst(trst), .start_i(start_i), .write_i(write_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .wstrb_i(wstrb_i),
        .busy_o(busy_o), .done_o(done_o), .resp_o(resp_o), .timeout_o(timeout_o),
        .overrun_o(overrun_o), .rdata_o(rdata_o), .txn_cnt_o(txn_cnt_o),
        .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid),
        .m_axi_awready(awready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_bresp(bresp),
        .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_araddr(araddr),
        .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid),
        .m_axi_rready(rready)
    );

    always @(posedge tck) begin
        if (!trst && awvalid && awready) aw_hs_cnt <= aw_hs_cnt + 1;
        if (!trst && wvalid && wready)   w_hs_cnt  <= w_hs_cnt + 1;
    end

    task automatic tick();
        @(posedge tck);
        #1;
    endtask

    task automatic test_reset();
        trst = 1'b1; start_i = 0; write_i = 0; addr_i = 0; wdata_i = 0; wstrb_i = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        tick(); tick();
        trst = 1'b0;
        checks++; if ({busy_o, done_o, timeout_o, overrun_o, resp_o} !== 6'b0) begin errors++; $display("FAIL reset_status: got %b exp 000000", {busy_o, done_o, timeout_o, overrun_o, resp_o}); end
        checks++; if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) begin errors++; $display("FAIL reset_axi: got %b exp 00000", {awvalid, wvalid, bready, arvalid, rready}); end
        checks++; if (rdata_o !== 32'h0 || txn_cnt_o !== 16'h0 || awaddr !== 32'h0) begin errors++; $display("FAIL reset_data: got rdata %h cnt %h addr %h exp 0", rdata_o, txn_cnt_o, awaddr); end
        checks++; if (awprot !== 3'b000 || arprot !== 3'b000) begin errors++; $display("FAIL prot: got %b/%b exp 000", awprot, arprot); end
    endtask

    task automatic test_zero_wait_write();
        start_i = 1; write_i = 1; addr_i = 32'h1000_0010; wdata_i = 32'hDEAD_BEEF; wstrb_i = 4'hF;
        awready = 1; wready = 1;
        tick();
        start_i = 0; addr_i = 0; wdata_i = 0; bvalid = 1; bresp = 2'b00;
        checks++; if ({awvalid, wvalid, busy_o, done_o} !== 4'b1110) begin errors++; $display("FAIL wr_n1_valids: got %b exp 1110", {awvalid, wvalid, busy_o, done_o}); end
        checks++; if (awaddr !== 32'h1000_0010 || wdata !== 32'hDEAD_BEEF || wstrb !== 4'hF) begin errors++; $display("FAIL wr_n1_payload: got %h %h %h", awaddr, wdata, wstrb); end
        tick();
        checks++; if ({awvalid, wvalid, bready} !== 3'b001) begin errors++; $display("FAIL wr_n2_bready: got %b exp 001", {awvalid, wvalid, bready}); end
        tick();
        bvalid = 0; awready = 0; wready = 0;
        checks++; if ({done_o, busy_o, bready, resp_o} !== 5'b10000 || txn_cnt_o !== 16'd1) begin errors++; $display("FAIL wr_done: got %b cnt %0d exp 10000 cnt 1", {done_o, busy_o, bready, resp_o}, txn_cnt_o); end
    endtask

    task automatic test_read_delayed();
        start_i = 1; write_i = 0; addr_i = 32'h2000_0004;
        tick();
        start_i = 0; addr_i = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            checks++; if (arvalid !== 1'b1 || araddr !== 32'h2000_0004 || busy_o !== 1'b1) begin errors++; $display("FAIL rd_ar_hold%0d: got v %b addr %h exp 1 20000004", i, arvalid, araddr); end
            tick();
        end
        arready = 1;
        tick();
        arready = 0;
        checks++; if ({arvalid, rready} !== 2'b01) begin errors++; $display("FAIL rd_rready: got %b exp 01", {arvalid, rready}); end
        rvalid = 1; rdata = 32'hCAFE_F00D; rresp = 2'b00;
        tick();
        rvalid = 0; rdata = 0;
        checks++; if (rdata_o !== 32'hCAFE_F00D || busy_o !== 1'b0 || done_o !== 1'b1 || rready !== 1'b0) begin errors++; $display("FAIL rd_done: got %h busy %b done %b", rdata_o, busy_o, done_o); end
        checks++; if (txn_cnt_o !== 16'd2 || resp_o !== 2'b00) begin errors++; $display("FAIL rd_cnt: got %0d resp %b exp 2 00", txn_cnt_o, resp_o); end
    endtask

    task automatic test_split_write();
        int aw0, w0;
        aw0 = aw_hs_cnt; w0 = w_hs_cnt;
        start_i = 1; write_i = 1; addr_i = 32'h3000_0000; wdata_i = 32'h0102_0304; wstrb_i = 4'h3;
        tick();
        start_i = 0; wready = 1;
        tick();
        wready = 0;
        for (int i = 0; i < 3; i++) begin
            checks++; if ({awvalid, wvalid, bready} !== 3'b100) begin errors++; $display("FAIL split_wait%0d: got %b exp 100", i, {awvalid, wvalid, bready}); end
            if (i == 2) awready = 1;
            tick();
        end
        awready = 0;
        checks++; if ({awvalid, wvalid, bready} !== 3'b001) begin errors++; $display("FAIL split_bready: got %b exp 001", {awvalid, wvalid, bready}); end
        checks++; if (aw_hs_cnt - aw0 !== 1 || w_hs_cnt - w0 !== 1) begin errors++; $display("FAIL split_hs_count: got aw %0d w %0d exp 1 1", aw_hs_cnt - aw0, w_hs_cnt - w0); end
        bvalid = 1; bresp = 2'b01;
        tick();
        bvalid = 0; bresp = 0;
        checks++; if (done_o !== 1'b1 || resp_o !== 2'b01 || txn_cnt_o !== 16'd3 || rdata_o !== 32'hCAFE_F00D) begin errors++; $display("FAIL split_done: got done %b resp %b cnt %0d rdata %h", done_o, resp_o, txn_cnt_o, rdata_o); end
    endtask

    task automatic test_timeout();
        start_i = 1; write_i = 0; addr_i = 32'h4000_0000;
        tick();
        start_i = 0;
        for (int i = 0; i < 15; i++) tick();
        checks++; if (busy_o !== 1'b1 || arvalid !== 1'b1 || done_o !== 1'b0) begin errors++; $display("FAIL tmo_early: got busy %b arv %b done %b exp 1 1 0", busy_o, arvalid, done_o); end
        tick();
        checks++; if ({busy_o, arvalid, done_o, timeout_o, resp_o} !== 6'b001110) begin errors++; $display("FAIL tmo_abort: got %b exp 001110", {busy_o, arvalid, done_o, timeout_o, resp_o}); end
        checks++; if (rdata_o !== 32'hCAFE_F00D || txn_cnt_o !== 16'd4) begin errors++; $display("FAIL tmo_data: got %h cnt %0d exp cafef00d 4", rdata_o, txn_cnt_o); end
    endtask

    task automatic test_overrun();
        start_i = 1; write_i = 0; addr_i = 32'h5000_0000; arready = 1;
        tick();
        start_i = 0;
        checks++; if (timeout_o !== 1'b0 || done_o !== 1'b0 || resp_o !== 2'b00) begin errors++; $display("FAIL start_clears: got tmo %b done %b resp %b exp 0 0 00", timeout_o, done_o, resp_o); end
        tick();
        arready = 0; start_i = 1; write_i = 1; addr_i = 32'h6000_0000;
        tick();
        start_i = 0;
        checks++; if ({overrun_o, busy_o, rready, awvalid} !== 4'b1110) begin errors++; $display("FAIL ovr_set: got %b exp 1110", {overrun_o, busy_o, rready, awvalid}); end
        rvalid = 1; rdata = 32'h1234_5678; rresp = 2'b00;
        tick();
        rvalid = 0;
        checks++; if (rdata_o !== 32'h1234_5678 || overrun_o !== 1'b1 || txn_cnt_o !== 16'd5 || araddr !== 32'h5000_0000) begin errors++; $display("FAIL ovr_read: got %h ovr %b cnt %0d addr %h", rdata_o, overrun_o, txn_cnt_o, araddr); end
        start_i = 1; write_i = 1; addr_i = 32'h6000_0000; wdata_i = 32'h5555_AAAA; awready = 1; wready = 1;
        tick();
        start_i = 0; bvalid = 1;
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b exp 0", overrun_o); end
        tick(); tick();
        bvalid = 0; awready = 0; wready = 0;
        checks++; if (txn_cnt_o !== 16'd6 || done_o !== 1'b1) begin errors++; $display("FAIL ovr_next_wr: got cnt %0d done %b exp 6 1", txn_cnt_o, done_o); end
    endtask

    task automatic test_reset_midflight();
        start_i = 1; write_i = 1; addr_i = 32'h7000_0000; wdata_i = 32'h0BAD_F00D; awready = 1; wready = 1;
        tick();
        start_i = 0;
        tick();
        awready = 0; wready = 0;
        checks++; if (bready !== 1'b1) begin errors++; $display("FAIL rst_pre_bready: got %b exp 1", bready); end
        trst = 1;
        tick();
        trst = 0;
        checks++; if ({awvalid, wvalid, bready, arvalid, rready, busy_o, done_o} !== 7'b0 || txn_cnt_o !== 16'd0 || rdata_o !== 32'h0) begin errors++; $display("FAIL rst_mid: got %b cnt %0d rdata %h", {awvalid, wvalid, bready, arvalid, rready, busy_o, done_o}, txn_cnt_o, rdata_o); end
        start_i = 1; write_i = 1; addr_i = 32'h8000_0000; awready = 1; wready = 1;
        tick();
        start_i = 0; bvalid = 1; bresp = 2'b00;
        tick(); tick();
        bvalid = 0;
        checks++; if (done_o !== 1'b1 || txn_cnt_o !== 16'd1 || busy_o !== 1'b0) begin errors++; $display("FAIL rst_recover: got done %b cnt %0d busy %b exp 1 1 0", done_o, txn_cnt_o, busy_o); end
    endtask

    initial begin
        test_reset();
        test_zero_wait_write();
        test_read_delayed();
        test_split_write();
        test_timeout();
        test_overrun();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
